// File: rtl/ttl_irq_encoder.sv
// Registered 8-line to 3-bit interrupt priority encoder with a request/acknowledge
// handshake; each serviced source stays masked until it releases its line.
module ttl_irq_encoder #(
  parameter int SYNC_STAGES = 2,
  parameter int DELAY_RISE  = 20,
  parameter int DELAY_FALL  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Req_n,
  input  logic       Ack,
  output logic       Irq_n,
  output logic [2:0] Vec,
  output logic       Any_n
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ASSERT = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  // The delays describe the board part's output timing only; clocked logic ignores them.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_param_check
    $error("ttl_irq_encoder: illegal parameter value");
  end

  logic [SYNC_STAGES*8-1:0] sync_q, sync_d;
  logic [7:0]               armed_q, armed_d;
  logic [1:0]               state_q, state_d;
  logic                     irq_n_q, irq_n_d;
  logic [2:0]               vec_q, vec_d;
  logic                     any_n_q, any_n_d;

  logic [7:0] sreq;
  logic [7:0] eligible;
  logic [2:0] prio;
  logic       ack_taken;

  assign sync_d   = {sync_q[(SYNC_STAGES-1)*8-1:0], Req_n};
  assign sreq     = ~sync_q[SYNC_STAGES*8-1 -: 8];
  assign eligible = sreq & armed_q;

  always_comb begin
    prio = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) prio = 3'(i);
    end
  end

  assign ack_taken = (state_q == ASSERT) && Ack;

  // A released line re-arms its source even in the cycle its acknowledge lands.
  always_comb begin
    armed_d = armed_q;
    if (ack_taken) armed_d[vec_q] = 1'b0;
    armed_d = armed_d | ~sreq;
  end

  always_comb begin
    state_d = state_q;
    irq_n_d = irq_n_q;
    vec_d   = vec_q;
    any_n_d = ~|eligible;
    case (state_q)
      IDLE: begin
        irq_n_d = 1'b1;
        if (eligible != 8'h00) begin
          vec_d   = prio;
          irq_n_d = 1'b0;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        irq_n_d = 1'b0;
        if (Ack) begin
          irq_n_d = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        irq_n_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        irq_n_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '1;
      armed_q <= 8'hFF;
      state_q <= IDLE;
      irq_n_q <= 1'b1;
      vec_q   <= 3'b000;
      any_n_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      armed_q <= armed_d;
      state_q <= state_d;
      irq_n_q <= irq_n_d;
      vec_q   <= vec_d;
      any_n_q <= any_n_d;
    end
  end

  assign Irq_n = irq_n_q;
  assign Vec   = vec_q;
  assign Any_n = any_n_q;

endmodule

// File: tb/tb_ttl_irq_encoder.sv
// Directed testbench for ttl_irq_encoder: handshake, priority freeze, re-arm and reset.
module tb_ttl_irq_encoder;

  logic       clk;
  logic       reset;
  logic [7:0] Req_n;
  logic       Ack;
  logic       Irq_n;
  logic [2:0] Vec;
  logic       Any_n;

  int total;
  int bad;

  ttl_irq_encoder #(.SYNC_STAGES(2), .DELAY_RISE(20), .DELAY_FALL(20)) dut (
    .clk   (clk),
    .reset (reset),
    .Req_n (Req_n),
    .Ack   (Ack),
    .Irq_n (Irq_n),
    .Vec   (Vec),
    .Any_n (Any_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_irq_low(input int max_edges, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_edges; i++) begin
      tick();
      if (Irq_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_ack();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
  endtask

  task automatic release_all();
    Req_n = 8'hFF;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Req_n = 8'hFF;
    Ack   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (Irq_n !== 1'b1 || Vec !== 3'd0 || Any_n !== 1'b1) begin
        bad++;
        $display("[TB] FAIL reset_idle cycle %0d: Irq_n=%b Vec=%0d Any_n=%b, required 1/0/1", i, Irq_n, Vec, Any_n);
      end
    end
  endtask

  task automatic test_single_rearm();
    bit ok;
    Req_n = 8'hF7;
    tick();
    tick();
    total++;
    if (Irq_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_early: Irq_n=%b after 2 edges, required 1", Irq_n);
    end
    tick();
    total++;
    if (Irq_n !== 1'b0 || Vec !== 3'd3 || Any_n !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_latency: Irq_n=%b Vec=%0d Any_n=%b, required 0/3/0", Irq_n, Vec, Any_n);
    end
    pulse_ack();
    total++;
    if (Irq_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_ack: Irq_n=%b, required 1", Irq_n);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (Irq_n !== 1'b1) begin
        bad++;
        $display("[TB] FAIL single_masked cycle %0d: Irq_n=%b, required 1", i, Irq_n);
      end
    end
    total++;
    if (Any_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_any_masked: Any_n=%b, required 1", Any_n);
    end
    Req_n = 8'hFF;
    tick();
    Req_n = 8'hF7;
    wait_irq_low(8, ok);
    total++;
    if (!ok || Vec !== 3'd3) begin
      bad++;
      $display("[TB] FAIL single_rearm: reached=%0d Vec=%0d, required reached=1 Vec=3", ok, Vec);
    end
    pulse_ack();
    release_all();
  endtask

  task automatic test_priority_freeze();
    bit ok;
    Req_n = 8'hFE;
    wait_irq_low(8, ok);
    total++;
    if (!ok || Vec !== 3'd0) begin
      bad++;
      $display("[TB] FAIL freeze_first: reached=%0d Vec=%0d, required reached=1 Vec=0", ok, Vec);
    end
    Req_n = 8'hBE;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (Irq_n !== 1'b0 || Vec !== 3'd0) begin
        bad++;
        $display("[TB] FAIL freeze_hold cycle %0d: Irq_n=%b Vec=%0d, required 0/0", i, Irq_n, Vec);
      end
    end
    pulse_ack();
    total++;
    if (Irq_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL freeze_ack: Irq_n=%b, required 1", Irq_n);
    end
    tick();
    total++;
    if (Irq_n !== 1'b1 || Vec !== 3'd0) begin
      bad++;
      $display("[TB] FAIL freeze_gap: Irq_n=%b Vec=%0d, required 1/0", Irq_n, Vec);
    end
    tick();
    total++;
    if (Irq_n !== 1'b0 || Vec !== 3'd6) begin
      bad++;
      $display("[TB] FAIL freeze_next: Irq_n=%b Vec=%0d, required 0/6", Irq_n, Vec);
    end
    pulse_ack();
    repeat (4) tick();
    total++;
    if (Irq_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL freeze_all_masked: Irq_n=%b, required 1", Irq_n);
    end
    release_all();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [2:0] order [4];
    order[0] = 3'd7;
    order[1] = 3'd5;
    order[2] = 3'd2;
    order[3] = 3'd0;
    Req_n = 8'h5A;
    wait_irq_low(8, ok);
    total++;
    if (!ok || Vec !== order[0]) begin
      bad++;
      $display("[TB] FAIL b2b_first: reached=%0d Vec=%0d, required reached=1 Vec=%0d", ok, Vec, order[0]);
    end
    for (int n = 1; n < 4; n++) begin
      pulse_ack();
      total++;
      if (Irq_n !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_ack %0d: Irq_n=%b, required 1", n, Irq_n);
      end
      tick();
      total++;
      if (Irq_n !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_gap %0d: Irq_n=%b, required 1", n, Irq_n);
      end
      tick();
      total++;
      if (Irq_n !== 1'b0 || Vec !== order[n]) begin
        bad++;
        $display("[TB] FAIL b2b_vec %0d: Irq_n=%b Vec=%0d, required 0/%0d", n, Irq_n, Vec, order[n]);
      end
    end
    pulse_ack();
    repeat (4) tick();
    total++;
    if (Irq_n !== 1'b1 || Any_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_done: Irq_n=%b Any_n=%b, required 1/1", Irq_n, Any_n);
    end
    release_all();
  endtask

  task automatic test_stray_ack();
    bit ok;
    pulse_ack();
    tick();
    total++;
    if (Irq_n !== 1'b1 || Any_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stray_idle: Irq_n=%b Any_n=%b, required 1/1", Irq_n, Any_n);
    end
    Req_n = 8'h7D;
    wait_irq_low(8, ok);
    total++;
    if (!ok || Vec !== 3'd7) begin
      bad++;
      $display("[TB] FAIL stray_first: reached=%0d Vec=%0d, required reached=1 Vec=7", ok, Vec);
    end
    pulse_ack();
    pulse_ack();
    total++;
    if (Irq_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stray_gap: Irq_n=%b, required 1", Irq_n);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (Irq_n !== 1'b0 || Vec !== 3'd1) begin
        bad++;
        $display("[TB] FAIL stray_after_gap cycle %0d: Irq_n=%b Vec=%0d, required 0/1", i, Irq_n, Vec);
      end
      tick();
    end
    pulse_ack();
    release_all();
    // Ack arrives at the same edge the new request is first seen in IDLE.
    Req_n = 8'hEF;
    tick();
    tick();
    pulse_ack();
    total++;
    if (Irq_n !== 1'b0 || Vec !== 3'd4) begin
      bad++;
      $display("[TB] FAIL stray_idle_edge: Irq_n=%b Vec=%0d, required 0/4", Irq_n, Vec);
    end
    repeat (2) tick();
    total++;
    if (Irq_n !== 1'b0 || Vec !== 3'd4) begin
      bad++;
      $display("[TB] FAIL stray_idle_hold: Irq_n=%b Vec=%0d, required 0/4", Irq_n, Vec);
    end
  endtask

  task automatic test_reset_mid_assert();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (Irq_n !== 1'b1 || Vec !== 3'd0 || Any_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_state: Irq_n=%b Vec=%0d Any_n=%b, required 1/0/1", Irq_n, Vec, Any_n);
    end
    tick();
    tick();
    total++;
    if (Irq_n !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_early: Irq_n=%b, required 1", Irq_n);
    end
    tick();
    total++;
    if (Irq_n !== 1'b0 || Vec !== 3'd4) begin
      bad++;
      $display("[TB] FAIL midreset_resignal: Irq_n=%b Vec=%0d, required 0/4", Irq_n, Vec);
    end
    pulse_ack();
    release_all();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    Req_n = 8'hFF;
    Ack   = 1'b0;
    test_reset();
    test_single_rearm();
    test_priority_freeze();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid_assert();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ttl_irq_encoder.md
# ttl_irq_encoder

Registered 8-line to 3-bit interrupt priority encoder with request/acknowledge handshake: the encoder counterpart to the 2-to-4 address decoders in the board glue logic. It synchronises eight active-low peripheral interrupt lines and presents the highest-priority pending source as a stable 3-bit vector with an active-low interrupt to the CPU. The vector is held until the CPU acknowledges it. Each serviced source is masked until it releases its line.

## Interface
Parameters:
- SYNC_STAGES, default 2: synchroniser depth on Req_n; legal range 2..3.
- DELAY_RISE, default 20: rise delay on the Irq_n, Vec and Any_n outputs.
- DELAY_FALL, default 20: fall delay on the Irq_n, Vec and Any_n outputs.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising clk edge.
- Req_n  input  8  asynchronous interrupt requests, active-low; bit 7 is highest priority.
- Ack  input  1  CPU acknowledge, one-cycle pulse; sampled high only in state ASSERT.
- Irq_n  output  1  interrupt to the CPU, active-low, registered.
- Vec  output  3  index of the source being signalled, registered; stable while Irq_n=0.
- Any_n  output  1  low when any eligible request exists (74148 GS-style); registered.

## Operation
- Synchroniser: SYNC_STAGES flops per bit; reset value 8'hFF. sreq = ~sync_out, so 1 means requesting.
- armed[7:0]: reset value 8'hFF.
  - armed[i] clears on an Ack that services source i.
  - armed[i] sets in any cycle where sreq[i]=0.
  - If both happen in the same cycle, set wins.
- eligible = sreq & armed.
- Priority: the highest set index of eligible.
- Any_n is registered as ~|eligible.
- State machine: IDLE, ASSERT, GAP. Reset state is IDLE.
  - IDLE: if eligible != 0, load Vec with the priority index, drive Irq_n to 0, and go to ASSERT. Otherwise hold, with Irq_n=1.
  - ASSERT: Irq_n=0 and Vec frozen. Higher-priority arrivals do not change Vec. Release of the latched source does not deassert Irq_n. When Ack=1: clear armed[Vec] (subject to the release-wins rule), drive Irq_n to 1, and go to GAP.
  - GAP: Irq_n=1 for exactly one cycle, then go to IDLE. Vec keeps its last value.
- Ack is ignored in IDLE and GAP.
- Reset mid-handshake returns the block to IDLE with Irq_n=1, Vec=0, Any_n=1, armed all 1s and the synchronisers all 1s. Any pending acknowledge is lost.
- Reset values: Irq_n=1, Vec=3'b000, Any_n=1.

## Timing
- Request latency: Req_n low and stable before edge k gives Irq_n=0 after edge k+SYNC_STAGES. With the default, that is 3 edges.
- Any_n follows eligible after the same SYNC_STAGES+1 edges.
- Ack latency: Ack sampled high at edge m in ASSERT gives Irq_n=1 after edge m.
  - The earliest next Irq_n=0 is after edge m+2, because GAP enforces at least one cycle high.
- Back-to-back service: if another source is eligible in IDLE after GAP, it asserts with no extra bubble beyond GAP.
- Re-arm: a serviced source can request again only after its sreq reads 0 for at least one cycle, i.e. Req_n high for at least one clk after synchronisation.
- Vec changes only on the IDLE-to-ASSERT transition.

## Test plan
- Reset then idle: hold reset 2 cycles with Req_n=8'hFF -> Irq_n=1, Vec=0 and Any_n=1 for 10 cycles.
- Single source, then release and re-request:
  - Req_n=8'hF7 -> Irq_n=0 and Vec=3 exactly 3 edges later.
  - Ack pulse -> Irq_n=1 on the next edge; no re-assert while Req_n[3] stays low.
  - Release Req_n[3] for 1 cycle and drop it again -> Vec=3 is re-signalled.
- Priority and freeze:
  - Req_n=8'hFE (source 0) until Irq_n=0 with Vec=0.
  - Then drop Req_n[6] -> Vec stays 0 until Ack.
  - Ack -> one GAP cycle with Irq_n=1, then Irq_n=0 with Vec=6.
- Simultaneous requests: Req_n=8'h5A (sources 7,5,2,0) -> Vec=7, 5, 2, 0 in successive handshakes, each separated by at least one Irq_n-high cycle.
- Stray Ack: pulse Ack in IDLE and in GAP -> no state change and no armed bit cleared.
- Reset mid-ASSERT: Irq_n=0 with Vec=4, assert reset for 1 cycle -> Irq_n=1 and Vec=0 after the edge, then Vec=4 is re-signalled SYNC_STAGES+1 edges after reset drops (Req_n[4] still low).
